// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and decode helper for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0101;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // MUL always iterates; DIV iterates unless the divisor is zero, which
   // completes immediately with the divide-by-zero flags.
   function automatic logic is_iterative(input logic [3:0] op, input logic b_zero);
      return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one step per enabled cycle.
// Exposes the post-step value so the final step's result can be written
// straight into the caller's output registers on the same edge.
module alu_muldiv_iter #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_step,
   output logic             o_last,
   output logic [WIDTH-1:0] o_result,
   output logic             o_ovr
);

   localparam int CW = $clog2(WIDTH + 1);

   // MUL: r_acc is the growing 2*WIDTH product, r_sr the multiplier shifting out.
   // DIV: r_acc[WIDTH:0] is the partial remainder, r_sr the dividend/quotient.
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_sr;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_is_div;
   logic [CW-1:0]      r_count;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_fits;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0]   w_sr_next;

   // One multiply or divide iteration computed from the current registers.
   always_comb begin
      w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
              + (r_sr[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
      w_shift = {r_acc[WIDTH-1:0], r_sr[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_opnd};
      w_fits  = (w_shift >= {1'b0, r_opnd});
      if (r_is_div) begin
         w_acc_next = {{(WIDTH-1){1'b0}}, (w_fits ? w_diff : w_shift)};
         w_sr_next  = {r_sr[WIDTH-2:0], w_fits};
      end else begin
         w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
         w_sr_next  = {1'b0, r_sr[WIDTH-1:1]};
      end
   end

   assign o_result = r_is_div ? w_sr_next : w_acc_next[WIDTH-1:0];
   assign o_ovr    = r_is_div ? 1'b0 : (|w_acc_next[2*WIDTH-1:WIDTH]);
   assign o_last   = (r_count == CW'(1));

   // Load operands on accept, then advance one iteration per step until count hits 0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc    <= {(2*WIDTH){1'b0}};
         r_sr     <= {WIDTH{1'b0}};
         r_opnd   <= {WIDTH{1'b0}};
         r_is_div <= 1'b0;
         r_count  <= {CW{1'b0}};
      end else if (i_load) begin
         r_acc    <= {(2*WIDTH){1'b0}};
         r_sr     <= i_a;
         r_opnd   <= i_b;
         r_is_div <= i_is_div;
         r_count  <= CW'(WIDTH);
      end else if (i_step && (r_count != {CW{1'b0}})) begin
         r_acc   <= w_acc_next;
         r_sr    <= w_sr_next;
         r_count <= r_count - CW'(1);
      end else begin
         r_acc   <= r_acc;
         r_sr    <= r_sr;
         r_count <= r_count;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with start/ready/valid handshake and registered flags.
// Single-cycle ops complete on the accepting edge; MUL/DIV run WIDTH iterations.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ctrl,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] Result,
   output logic             Ovr,
   output logic             Zero,
   output logic             DivZero
);

   import alu_pkg::*;

   state_t           r_state;
   logic             r_ready;
   logic             r_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_ovr;
   logic             r_zero;
   logic             r_divzero;

   logic             w_b_zero;
   logic             w_load;
   logic             w_busy;
   logic             w_is_div;
   logic             w_last;
   logic [WIDTH-1:0] w_iter_res;
   logic             w_iter_ovr;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH-1:0] w_res1;
   logic             w_ovr1;
   logic             w_dz1;

   assign w_b_zero = (B == {WIDTH{1'b0}});
   assign w_busy   = (r_state == BUSY);
   assign w_is_div = (ctrl == OP_DIV);
   assign w_load   = start && (r_state == IDLE) && is_iterative(ctrl, w_b_zero);

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_load   (w_load),
      .i_is_div (w_is_div),
      .i_a      (A),
      .i_b      (B),
      .i_step   (w_busy),
      .o_last   (w_last),
      .o_result (w_iter_res),
      .o_ovr    (w_iter_ovr)
   );

   // Single-cycle datapath; DIV here only ever sees the divide-by-zero case.
   always_comb begin
      w_add  = {1'b0, A} + {1'b0, B};
      w_sub  = {1'b0, A} - {1'b0, B};
      w_res1 = {WIDTH{1'b0}};
      w_ovr1 = 1'b0;
      w_dz1  = 1'b0;
      case (ctrl)
         OP_AND: w_res1 = A & B;
         OP_OR:  w_res1 = A | B;
         OP_ADD: begin
            w_res1 = w_add[WIDTH-1:0];
            w_ovr1 = w_add[WIDTH];
         end
         OP_SUB: begin
            w_res1 = w_sub[WIDTH-1:0];
            w_ovr1 = w_sub[WIDTH];
         end
         OP_DIV: begin
            w_res1 = {WIDTH{1'b1}};
            w_ovr1 = 1'b1;
            w_dz1  = 1'b1;
         end
         OP_SLT: w_res1 = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_NOR: w_res1 = ~(A | B);
         default: begin
            w_res1 = {WIDTH{1'b0}};
            w_ovr1 = 1'b0;
            w_dz1  = 1'b0;
         end
      endcase
   end

   // Control FSM and output registers; outputs change only on completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ready   <= 1'b1;
         r_valid   <= 1'b0;
         r_result  <= {WIDTH{1'b0}};
         r_ovr     <= 1'b0;
         r_zero    <= 1'b1;
         r_divzero <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_load) begin
                  r_state <= BUSY;
                  r_ready <= 1'b0;
               end else if (start) begin
                  r_result  <= w_res1;
                  r_ovr     <= w_ovr1;
                  r_zero    <= (w_res1 == {WIDTH{1'b0}});
                  r_divzero <= w_dz1;
                  r_valid   <= 1'b1;
                  r_ready   <= 1'b1;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            BUSY: begin
               if (w_last) begin
                  r_result  <= w_iter_res;
                  r_ovr     <= w_iter_ovr;
                  r_zero    <= (w_iter_res == {WIDTH{1'b0}});
                  r_divzero <= 1'b0;
                  r_valid   <= 1'b1;
                  r_state   <= IDLE;
                  r_ready   <= 1'b1;
               end else begin
                  r_ready <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready   = r_ready;
   assign valid   = r_valid;
   assign Result  = r_result;
   assign Ovr     = r_ovr;
   assign Zero    = r_zero;
   assign DivZero = r_divzero;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model plus directed cases.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic [3:0]   ctrl = 4'b0000;
   logic         ready, valid, Ovr, Zero, DivZero;
   logic [W-1:0] Result;

   int n_pass = 0;
   int n_total = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .ctrl(ctrl),
      .ready(ready), .valid(valid), .Result(Result), .Ovr(Ovr),
      .Zero(Zero), .DivZero(DivZero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference arithmetic straight from the opcode table.
   function automatic void ref_op(input logic [3:0] c, input longint a, input longint b,
                                  output longint res, output longint ovr,
                                  output longint dz, output bit multi);
      longint mask = (longint'(1) << W) - 1;
      longint t;
      res = 0; ovr = 0; dz = 0; multi = 0;
      case (c)
         4'b0000: res = a & b;
         4'b0001: res = a | b;
         4'b0010: begin t = a + b; res = t & mask; ovr = (t > mask); end
         4'b0011: begin res = (a - b) & mask; ovr = (a < b); end
         4'b0100: begin t = a * b; res = t & mask; ovr = (t > mask); multi = 1; end
         4'b0101: begin
            if (b == 0) begin res = mask; ovr = 1; dz = 1; end
            else begin res = a / b; multi = 1; end
         end
         4'b0111: res = (a < b) ? 1 : 0;
         4'b1100: res = ~(a | b) & mask;
         default: res = 0;
      endcase
   endfunction

   // Model state: expected outputs after each edge.
   longint m_edge = 0, m_last_done = -1, m_pend_edge = 0;
   bit     m_pend = 0;
   longint p_res, p_ovr, p_dz;
   longint exp_res = 0, exp_ovr = 0, exp_dz = 0;
   bit     exp_valid = 0, exp_ready = 1, exp_zero = 1;

   always @(posedge clk or posedge rst) begin
      longint r, o, d;
      bit mu;
      if (rst) begin
         m_edge = 0; m_last_done = -1; m_pend = 0;
         exp_valid = 0; exp_ready = 1; exp_res = 0; exp_ovr = 0; exp_zero = 1; exp_dz = 0;
      end else begin
         m_edge++;
         exp_valid = 0;
         if (m_pend && m_edge == m_pend_edge) begin
            exp_res = p_res; exp_ovr = p_ovr; exp_dz = p_dz; exp_zero = (p_res == 0);
            exp_valid = 1; m_pend = 0;
         end
         if (start && m_edge > m_last_done) begin
            ref_op(ctrl, longint'(A), longint'(B), r, o, d, mu);
            if (mu) begin
               m_pend = 1; m_pend_edge = m_edge + W; m_last_done = m_pend_edge;
               p_res = r; p_ovr = o; p_dz = d;
            end else begin
               exp_res = r; exp_ovr = o; exp_dz = d; exp_zero = (r == 0);
               exp_valid = 1; m_last_done = m_edge;
            end
         end
         exp_ready = (m_edge >= m_last_done);
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("valid", valid, exp_valid);
         chk("ready", ready, exp_ready);
         chk("Result", Result, exp_res);
         chk("Ovr", Ovr, exp_ovr);
         chk("Zero", Zero, exp_zero);
         chk("DivZero", DivZero, exp_dz);
      end
   end

   // Issue one op, wait (bounded) for valid, check hand-computed literals.
   // poke_at>0 pulses an ignored start while busy and checks no extra valid.
   task automatic run_op(input logic [3:0] c, input int a, input int b,
                         input int e_res, input int e_ovr, input int e_dz,
                         input int e_n, input int poke_at);
      int n = 0;
      int extra = 0;
      bit seen = 0;
      @(negedge clk);
      ctrl = c; A = W'(a); B = W'(b); start = 1'b1;
      @(posedge clk);
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (valid) seen = 1;
         start = 1'b0;
         A = W'($urandom); B = W'($urandom); ctrl = 4'($urandom);
         if (n == poke_at) begin start = 1'b1; ctrl = 4'b0010; end
      end
      chk("negedges_to_valid", n, e_n);
      chk("lit_Result", Result, e_res);
      chk("lit_Ovr", Ovr, e_ovr);
      chk("lit_DivZero", DivZero, e_dz);
      chk("lit_Zero", Zero, (e_res == 0) ? 1 : 0);
      if (poke_at > 0) begin
         repeat (4) begin
            @(negedge clk);
            if (valid) extra++;
         end
         chk("ignored_start_no_valid", extra, 0);
      end
   endtask

   initial begin
      int nv;
      logic [3:0] ops [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'hC, 4'h6, 4'h8, 4'hF};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_Result", Result, 0);
      chk("rst_Zero", Zero, 1);
      chk("rst_Ovr", Ovr, 0);
      chk("rst_DivZero", DivZero, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ready", ready, 1);
      #1 rst = 1'b0;

      run_op(4'b0010, 200, 100, 44, 1, 0, 1, 0);
      run_op(4'b0011, 5, 5, 0, 0, 0, 1, 0);
      run_op(4'b0100, 20, 15, 44, 1, 0, W + 1, 3);
      run_op(4'b0100, 15, 17, 255, 0, 0, W + 1, 0);
      run_op(4'b0101, 200, 7, 28, 0, 0, W + 1, 0);
      run_op(4'b0101, 9, 0, 255, 1, 1, 1, 0);

      // Reset four cycles into MUL 255x255 aborts it.
      @(negedge clk);
      ctrl = 4'b0100; A = 8'd255; B = 8'd255; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_Result", Result, 0);
      chk("abort_Zero", Zero, 1);
      chk("abort_valid", valid, 0);
      chk("abort_ready", ready, 1);
      @(negedge clk); #1 rst = 1'b0;
      nv = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (valid) nv++;
      end
      chk("abort_no_completion", nv, 0);
      run_op(4'b0010, 1, 1, 2, 0, 0, 1, 0);

      // Back-to-back single-cycle ops.
      @(negedge clk);
      ctrl = 4'b0111; A = 8'd3; B = 8'd7; start = 1'b1;
      @(negedge clk);
      chk("b2b1_valid", valid, 1); chk("b2b1_Result", Result, 1); chk("b2b1_Zero", Zero, 0);
      ctrl = 4'b1100; A = 8'hF0; B = 8'h0F;
      @(negedge clk);
      chk("b2b2_valid", valid, 1); chk("b2b2_Result", Result, 0); chk("b2b2_Zero", Zero, 1);
      ctrl = 4'b0001; A = 8'h00; B = 8'h00;
      @(negedge clk);
      chk("b2b3_valid", valid, 1); chk("b2b3_Result", Result, 0); chk("b2b3_Zero", Zero, 1);
      start = 1'b0;

      run_op(4'b0110, 255, 255, 0, 0, 0, 1, 0);

      // Randomized traffic, checked cycle by cycle against the model.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) != 0);
         ctrl = ops[$urandom_range(0, 10)];
         A = W'($urandom);
         B = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      end
      @(negedge clk); start = 1'b0;
      repeat (W + 3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
